// File: rtl/step_fsm_sched_pkg.sv
// -----------------------------------------------------------------------------
// step_fsm_pkg
//   Shared definitions for the step-engine scheduler:
//   - ctrl_e      : controller state encoding (IDLE, GRANT, STEP, GAPW, DONE)
//   - ST0..ST4    : engine state constants, ST_LAST is the wrap-around state
//   - next_st()   : shadow copy of one engine advance
//   - hold_lvl()  : DIN1 level that keeps the engine where it is
// -----------------------------------------------------------------------------
package step_fsm_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    STEP  = 3'd2,
    GAPW  = 3'd3,
    DONE  = 3'd4
  } ctrl_e;

  localparam logic [2:0] ST0     = 3'd0;
  localparam logic [2:0] ST1     = 3'd1;
  localparam logic [2:0] ST2     = 3'd2;
  localparam logic [2:0] ST3     = 3'd3;
  localparam logic [2:0] ST4     = 3'd4;
  localparam logic [2:0] ST_LAST = ST4;

  // One engine step: 0..3 count up, the last state wraps to 0.
  function automatic logic [2:0] next_st(input logic [2:0] st);
    return (st == ST_LAST) ? ST0 : st + 3'd1;
  endfunction

  // The engine holds in 0..3 on DIN1=0 but in the last state on DIN1=1,
  // so the hold level depends on where the engine sits.
  function automatic logic hold_lvl(input logic [2:0] st);
    return (st == ST_LAST);
  endfunction

endpackage

// File: rtl/step_fsm_sched_if.sv
// -----------------------------------------------------------------------------
// step_fsm_sched_if
//   Requester/engine-side bundle of the step-engine scheduler.
//   Requester side : REQ, CNT0, CNT1, MODE  -> scheduler
//   Scheduler side : GNT, ADV (DIN1), SEL (DIN2), SPST, BUSY, DONE
//   With STEP_FSM_SCHED_CHECK_EN defined: ENG_PST (engine's real state) in,
//   MISMATCH (sticky shadow/engine disagreement flag) out.
//   Modports: master = requester/engine side, slave = scheduler.
// -----------------------------------------------------------------------------
interface step_fsm_sched_if #(
  parameter int CW = 3
);
  logic [1:0]    REQ;
  logic [CW-1:0] CNT0;
  logic [CW-1:0] CNT1;
  logic [1:0]    MODE;
  logic [1:0]    GNT;
  logic          ADV;
  logic          SEL;
  logic [2:0]    SPST;
  logic          BUSY;
  logic          DONE;

`ifdef STEP_FSM_SCHED_CHECK_EN
  logic [2:0]    ENG_PST;
  logic          MISMATCH;

  modport master (
    output REQ, CNT0, CNT1, MODE, ENG_PST,
    input  GNT, ADV, SEL, SPST, BUSY, DONE, MISMATCH
  );
  modport slave (
    input  REQ, CNT0, CNT1, MODE, ENG_PST,
    output GNT, ADV, SEL, SPST, BUSY, DONE, MISMATCH
  );
`else
  modport master (
    output REQ, CNT0, CNT1, MODE,
    input  GNT, ADV, SEL, SPST, BUSY, DONE
  );
  modport slave (
    input  REQ, CNT0, CNT1, MODE,
    output GNT, ADV, SEL, SPST, BUSY, DONE
  );
`endif

endinterface

// File: rtl/step_fsm_sched_arb.sv
// -----------------------------------------------------------------------------
// rr_arb2
//   Two-way round-robin arbiter.
//   CLK, RST : clock, asynchronous active-low reset
//   req      : request vector
//   upd      : pointer-update strobe (end of a job)
//   last     : one-hot grant of the job that is ending
//   win      : one-hot winner, combinational from req and the pointer
// -----------------------------------------------------------------------------
module rr_arb2 (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic [1:0] last,
  output logic [1:0] win
);

  // 0: requester 0 wins a tie, 1: requester 1 wins a tie.
  logic ptr;

  // NOTE: state is written with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ptr <= 1'b0;
    end else if (upd) begin
      // Priority goes to whoever was not just served.
      ptr <= last[0];
    end
  end

  // NOTE: win gets a default before the case so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    win = 2'b00;
    case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = ptr ? 2'b10 : 2'b01;
      default: win = 2'b00;
    endcase
  end

endmodule

// File: rtl/step_fsm_sched.sv
// -----------------------------------------------------------------------------
// step_fsm_sched
//   Arbitrates two requesters onto a 5-state step engine. Each granted job
//   issues CNTx (0 treated as 1) single-cycle step pulses on ADV, separated by
//   GAP hold cycles, with SEL fixed to the requester's MODE bit for the job.
//   SPST shadows the engine state.
//   Parameters: GAP (0..15) hold cycles between steps, CW count width.
//   Ports: CLK, RST (async active-low), bus (step_fsm_sched_if.slave).
//   Optional: STEP_FSM_SCHED_CHECK_EN adds ENG_PST/MISMATCH compare logic.
// -----------------------------------------------------------------------------
module step_fsm_sched
  import step_fsm_pkg::*;
#(
  parameter int GAP = 1,
  parameter int CW  = 3
) (
  input  logic             CLK,
  input  logic             RST,
  step_fsm_sched_if.slave  bus
);

  localparam logic [2:0]    S_IDLE  = IDLE;
  localparam logic [2:0]    S_GRANT = GRANT;
  localparam logic [2:0]    S_STEP  = STEP;
  localparam logic [2:0]    S_GAPW  = GAPW;
  localparam logic [2:0]    S_DONE  = DONE;
  localparam logic [3:0]    GAP_L   = 4'(GAP);
  localparam logic [CW-1:0] ONE     = CW'(1);

  logic [2:0]    state;
  logic [2:0]    spst;
  logic [1:0]    gnt;
  logic          sel;
  logic [CW-1:0] step_cnt;
  logic [3:0]    gap_cnt;
  logic [1:0]    win;
  logic [CW-1:0] win_cnt;
  logic          win_mode;
  logic          hold;
  logic          busy;

  rr_arb2 u_arb (
    .CLK  (CLK),
    .RST  (RST),
    .req  (bus.REQ),
    .upd  (state == S_DONE),
    .last (gnt),
    .win  (win)
  );

  assign win_cnt  = win[1] ? bus.CNT1    : bus.CNT0;
  assign win_mode = win[1] ? bus.MODE[1] : bus.MODE[0];
  assign hold     = hold_lvl(spst);
  assign busy     = (state != S_IDLE);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= S_IDLE;
      spst     <= ST0;
      gnt      <= 2'b00;
      sel      <= 1'b0;
      step_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|bus.REQ) begin
            state    <= S_GRANT;
            gnt      <= win;
            sel      <= win_mode;
            step_cnt <= (win_cnt == '0) ? ONE : win_cnt;
          end
        end
        S_GRANT: state <= S_STEP;
        S_STEP: begin
          spst     <= next_st(spst);
          step_cnt <= step_cnt - ONE;
          if (step_cnt == ONE) begin
            state <= S_DONE;
          end else if (GAP_L == 4'd0) begin
            state <= S_STEP;
          end else begin
            state   <= S_GAPW;
            gap_cnt <= GAP_L;
          end
        end
        S_GAPW: begin
          gap_cnt <= gap_cnt - 4'd1;
          if (gap_cnt == 4'd1) state <= S_STEP;
        end
        S_DONE: begin
          state <= S_IDLE;
          gnt   <= 2'b00;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Only the STEP cycle drives the opposite of the hold level.
  assign bus.ADV  = (state == S_STEP) ? ~hold : hold;
  assign bus.SEL  = sel;
  assign bus.GNT  = gnt;
  assign bus.SPST = spst;
  assign bus.BUSY = busy;
  assign bus.DONE = (state == S_DONE);

`ifdef STEP_FSM_SCHED_CHECK_EN
  logic mismatch;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mismatch <= 1'b0;
    end else if (busy && (bus.ENG_PST != spst)) begin
      mismatch <= 1'b1;
    end
  end

  assign bus.MISMATCH = mismatch;
`endif

endmodule

// File: tb/tb_step_fsm_sched.sv
// -----------------------------------------------------------------------------
// tb_step_fsm_sched
//   Two scheduler instances: index 0 with GAP=0, index 1 with GAP=1.
//   Expected per-cycle outputs of each job are generated from a job-level
//   description (grant, N steps with gap cycles between them, done, idle).
// -----------------------------------------------------------------------------
module tb_step_fsm_sched;

  localparam int CW = 3;

  typedef struct packed {
    logic [1:0] gnt;
    logic       busy;
    logic       adv;
    logic       done;
    logic       sel;
    logic [2:0] spst;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  step_fsm_sched_if #(.CW(CW)) bus_g0 ();
  step_fsm_sched_if #(.CW(CW)) bus_g1 ();

  step_fsm_sched #(.GAP(0), .CW(CW)) dut_g0 (.CLK(CLK), .RST(RST), .bus(bus_g0.slave));
  step_fsm_sched #(.GAP(1), .CW(CW)) dut_g1 (.CLK(CLK), .RST(RST), .bus(bus_g1.slave));

  logic [1:0]    req_d  [2];
  logic [CW-1:0] cnt0_d [2];
  logic [CW-1:0] cnt1_d [2];
  logic [1:0]    mode_d [2];
  logic [2:0]    eng_d  [2];

  logic [1:0] gnt_o  [2];
  logic       adv_o  [2];
  logic       sel_o  [2];
  logic [2:0] spst_o [2];
  logic       busy_o [2];
  logic       done_o [2];

  assign bus_g0.REQ  = req_d[0];
  assign bus_g0.CNT0 = cnt0_d[0];
  assign bus_g0.CNT1 = cnt1_d[0];
  assign bus_g0.MODE = mode_d[0];
  assign bus_g1.REQ  = req_d[1];
  assign bus_g1.CNT0 = cnt0_d[1];
  assign bus_g1.CNT1 = cnt1_d[1];
  assign bus_g1.MODE = mode_d[1];

  assign gnt_o[0]  = bus_g0.GNT;
  assign adv_o[0]  = bus_g0.ADV;
  assign sel_o[0]  = bus_g0.SEL;
  assign spst_o[0] = bus_g0.SPST;
  assign busy_o[0] = bus_g0.BUSY;
  assign done_o[0] = bus_g0.DONE;
  assign gnt_o[1]  = bus_g1.GNT;
  assign adv_o[1]  = bus_g1.ADV;
  assign sel_o[1]  = bus_g1.SEL;
  assign spst_o[1] = bus_g1.SPST;
  assign busy_o[1] = bus_g1.BUSY;
  assign done_o[1] = bus_g1.DONE;

`ifdef STEP_FSM_SCHED_CHECK_EN
  assign bus_g0.ENG_PST = eng_d[0];
  assign bus_g1.ENG_PST = eng_d[1];
`endif

  // Reference model: engine position and tie-break owner per instance.
  int   m_spst [2];
  int   m_ptr  [2];
  exp_t exp_q  [$];

  function automatic int gap_of(input int d);
    return (d == 0) ? 0 : 1;
  endfunction

  function automatic exp_t mk(input logic [1:0] g, input logic b, input logic a,
                              input logic dn, input logic sl, input logic [2:0] s);
    exp_t e;
    e.gnt = g; e.busy = b; e.adv = a; e.done = dn; e.sel = sl; e.spst = s;
    return e;
  endfunction

  function automatic exp_t obs(input int d);
    return mk(gnt_o[d], busy_o[d], adv_o[d], done_o[d], sel_o[d], spst_o[d]);
  endfunction

  // Engine holds on DIN1=0 in states 0..3 and on DIN1=1 in state 4.
  function automatic logic hold_of(input int s);
    return (s == 4);
  endfunction

  // Cycle list of one job, starting with the grant cycle and ending with the
  // idle cycle that follows DONE.
  task automatic build_job(input int d, input int n, input int w, input logic mode);
    int         s;
    logic [1:0] g;
    s = m_spst[d];
    g = (w == 0) ? 2'b01 : 2'b10;
    exp_q.push_back(mk(g, 1'b1, hold_of(s), 1'b0, mode, 3'(s)));
    for (int k = 1; k <= n; k++) begin
      exp_q.push_back(mk(g, 1'b1, ~hold_of(s), 1'b0, mode, 3'(s)));
      s = (s + 1) % 5;
      if (k < n)
        for (int j = 0; j < gap_of(d); j++)
          exp_q.push_back(mk(g, 1'b1, hold_of(s), 1'b0, mode, 3'(s)));
    end
    exp_q.push_back(mk(g, 1'b1, hold_of(s), 1'b1, mode, 3'(s)));
    exp_q.push_back(mk(2'b00, 1'b0, hold_of(s), 1'b0, mode, 3'(s)));
    m_spst[d] = s;
    m_ptr[d]  = (w == 0) ? 1 : 0;
  endtask

  // Called between a falling and the next rising edge with the instance idle.
  // Returns right after the falling edge of the idle cycle following DONE.
  task automatic job(input int d, input logic [1:0] req, input int c0, input int c1,
                     input logic [1:0] md, input bit keep, input string tag);
    int   w, n, cyc;
    exp_t e, o;
    if (req == 2'b11) w = m_ptr[d];
    else              w = req[1] ? 1 : 0;
    n = (w == 0) ? c0 : c1;
    if (n == 0) n = 1;
    build_job(d, n, w, md[w]);
    req_d[d]  = req;
    cnt0_d[d] = CW'(c0);
    cnt1_d[d] = CW'(c1);
    mode_d[d] = md;
    @(posedge CLK);
    cyc = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge CLK);
      o = obs(d);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL %s dut%0d cyc=%0d got gnt=%b busy=%b adv=%b done=%b sel=%b spst=%0d exp gnt=%b busy=%b adv=%b done=%b sel=%b spst=%0d",
                 tag, d, cyc, o.gnt, o.busy, o.adv, o.done, o.sel, o.spst,
                 e.gnt, e.busy, e.adv, e.done, e.sel, e.spst);
      end
      if (cyc == 0 && !keep) req_d[d] = 2'b00;
      cyc++;
    end
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    RST = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_d[d] = 2'b00; cnt0_d[d] = '0; cnt1_d[d] = '0; mode_d[d] = 2'b00; eng_d[d] = 3'd0;
      m_spst[d] = 0; m_ptr[d] = 0;
    end
    @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic test_reset();
    exp_t o;
    for (int d = 0; d < 2; d++) begin
      req_d[d] = 2'b11; cnt0_d[d] = '0; cnt1_d[d] = '0; mode_d[d] = 2'b11; eng_d[d] = 3'd0;
      m_spst[d] = 0; m_ptr[d] = 0;
    end
    @(posedge CLK);
    #2;
    for (int d = 0; d < 2; d++) begin
      o = obs(d);
      checks++;
      if (o !== mk(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0)) begin
        failures++;
        $display("FAIL reset dut%0d got gnt=%b busy=%b adv=%b done=%b sel=%b spst=%0d exp all zero",
                 d, o.gnt, o.busy, o.adv, o.done, o.sel, o.spst);
      end
`ifdef STEP_FSM_SCHED_CHECK_EN
      checks++;
      if ((d == 0 ? bus_g0.MISMATCH : bus_g1.MISMATCH) !== 1'b0) begin
        failures++;
        $display("FAIL reset_mismatch dut%0d got %b exp 0", d,
                 d == 0 ? bus_g0.MISMATCH : bus_g1.MISMATCH);
      end
`endif
      req_d[d] = 2'b00; mode_d[d] = 2'b00;
    end
    @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic test_basic();
    job(1, 2'b01, 3, 0, 2'b01, 1'b0, "basic_gap1");
  endtask

  task automatic test_gap0_wrap();
    job(0, 2'b01, 3, 0, 2'b00, 1'b0, "gap0_to3");
    job(0, 2'b10, 0, 2, 2'b10, 1'b0, "gap0_wrap");
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      checks++;
      if (adv_o[0] !== 1'b0 || spst_o[0] !== 3'd0 || busy_o[0] !== 1'b0) begin
        failures++;
        $display("FAIL gap0_idle got adv=%b spst=%0d busy=%b exp adv=0 spst=0 busy=0",
                 adv_o[0], spst_o[0], busy_o[0]);
      end
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    job(1, 2'b11, 1, 1, 2'b10, 1'b1, "rr_first");
    job(1, 2'b11, 1, 1, 2'b10, 1'b1, "rr_second");
    job(1, 2'b11, 1, 1, 2'b10, 1'b0, "rr_third");
  endtask

  task automatic test_cnt_zero();
    job(1, 2'b01, 0, 5, 2'b01, 1'b0, "cnt_zero");
  endtask

  task automatic test_hold4();
    int n;
    n = (4 - m_spst[1] + 5) % 5;
    if (n != 0) job(1, 2'b01, n, 0, 2'b00, 1'b0, "reach4");
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      checks++;
      if (adv_o[1] !== 1'b1 || spst_o[1] !== 3'd4 || busy_o[1] !== 1'b0) begin
        failures++;
        $display("FAIL hold4 cyc=%0d got adv=%b spst=%0d busy=%b exp adv=1 spst=4 busy=0",
                 i, adv_o[1], spst_o[1], busy_o[1]);
      end
    end
  endtask

  // Five-step job, reset asserted during the second gap cycle.
  task automatic test_reset_mid();
    int s2;
    s2 = (m_spst[1] + 2) % 5;
    req_d[1] = 2'b01; cnt0_d[1] = CW'(5); mode_d[1] = 2'b01;
    repeat (5) @(posedge CLK);
    #1;
    checks++;
    if (busy_o[1] !== 1'b1 || gnt_o[1] !== 2'b01 || spst_o[1] !== 3'(s2) || adv_o[1] !== hold_of(s2)) begin
      failures++;
      $display("FAIL mid_gapw got busy=%b gnt=%b spst=%0d adv=%b exp busy=1 gnt=01 spst=%0d adv=%b",
               busy_o[1], gnt_o[1], spst_o[1], adv_o[1], s2, hold_of(s2));
    end
    #1;
    RST = 1'b0;
    #1;
    checks++;
    if (obs(1) !== mk(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0)) begin
      failures++;
      $display("FAIL mid_reset got gnt=%b busy=%b adv=%b done=%b sel=%b spst=%0d exp all zero",
               gnt_o[1], busy_o[1], adv_o[1], done_o[1], sel_o[1], spst_o[1]);
    end
    apply_reset();
  endtask

  task automatic test_random();
    int d;
    for (int i = 0; i < 16; i++) begin
      d = int'($urandom_range(0, 1));
      job(d, 2'($urandom_range(1, 3)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
          2'($urandom_range(0, 3)), 1'b0, "random");
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end
  endtask

`ifdef STEP_FSM_SCHED_CHECK_EN
  task automatic test_mismatch();
    int  guard;
    apply_reset();
    req_d[1] = 2'b01; cnt0_d[1] = CW'(3); mode_d[1] = 2'b00; eng_d[1] = 3'd0;
    @(posedge CLK);                      // -> GRANT
    @(negedge CLK);
    req_d[1] = 2'b00;
    checks++;
    if (bus_g1.MISMATCH !== 1'b0) begin
      failures++;
      $display("FAIL mm_grant got %b exp 0", bus_g1.MISMATCH);
    end
    @(posedge CLK);                      // -> STEP, shadow 0
    @(posedge CLK);                      // -> GAPW, shadow 1
    @(negedge CLK);
    checks++;
    if (bus_g1.MISMATCH !== 1'b0 || spst_o[1] !== 3'd1 || busy_o[1] !== 1'b1) begin
      failures++;
      $display("FAIL mm_match got mm=%b spst=%0d busy=%b exp mm=0 spst=1 busy=1",
               bus_g1.MISMATCH, spst_o[1], busy_o[1]);
    end
    eng_d[1] = 3'd2;
    @(negedge CLK);
    eng_d[1] = 3'd1;
    checks++;
    if (bus_g1.MISMATCH !== 1'b1) begin
      failures++;
      $display("FAIL mm_set got %b exp 1", bus_g1.MISMATCH);
    end
    guard = 0;
    while (busy_o[1] === 1'b1 && guard < 20) begin
      @(negedge CLK);
      guard++;
    end
    checks++;
    if (guard >= 20) begin
      failures++;
      $display("FAIL mm_job_end got busy=%b after %0d cycles exp 0", busy_o[1], guard);
    end
    repeat (2) @(negedge CLK);
    checks++;
    if (bus_g1.MISMATCH !== 1'b1) begin
      failures++;
      $display("FAIL mm_sticky got %b exp 1", bus_g1.MISMATCH);
    end
    apply_reset();
    checks++;
    if (bus_g1.MISMATCH !== 1'b0) begin
      failures++;
      $display("FAIL mm_clear got %b exp 0", bus_g1.MISMATCH);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_gap0_wrap();
    test_round_robin();
    test_cnt_zero();
    test_hold4();
    test_reset_mid();
    test_random();
`ifdef STEP_FSM_SCHED_CHECK_EN
    test_mismatch();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
